pipelined_lod_normalizer: RTL and testbench

//  Parametrised, pipelined successor to the combinational leading-one detector.

---
 rtl/pipelined_lod_normalizer_if.sv | 27 ++
 rtl/pipelined_lod_normalizer.sv | 114 +++++++++++
 tb/tb_pipelined_lod_normalizer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_lod_normalizer_if.sv
// Handshake bundle for the leading-one normaliser: input valid/ready/bits
// and the result channel. The master side feeds beats and consumes results;
// the slave side is the normaliser itself.
interface pipelined_lod_normalizer_if #(
    parameter int WIDTH = 23,
    parameter int POS_W = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bits;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] out_pos;
    logic             out_zero;
    logic [POS_W-1:0] out_shift;
    logic [WIDTH-1:0] out_norm;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_pos, out_zero, out_shift, out_norm
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_pos, out_zero, out_shift, out_norm
    );
endinterface

// File: rtl/pipelined_lod_normalizer.sv
// Two-stage leading-one detector and left-normaliser.
// S1 captures the mantissa with its leading-one position and zero flag;
// S2 holds the shift amount and normalised mantissa and drives every output.
// Each stage advances when its downstream slot is free or being emptied, so
// two beats can be buffered and the pipeline streams one beat per cycle.
module pipelined_lod_normalizer #(
    parameter int WIDTH = 23,
    parameter int POS_W = $clog2(WIDTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    pipelined_lod_normalizer_if.slave io
);

    localparam logic [POS_W-1:0] WIDTH_P = POS_W'(WIDTH);

    // Index+1 of the highest set bit, 0 for an all-zero word. Later
    // iterations overwrite earlier ones, so the highest set bit wins.
    function automatic logic [POS_W-1:0] lead_pos(input logic [WIDTH-1:0] v);
        logic [POS_W-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) p = POS_W'(i + 1);
        end
        return p;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_bits_q,  s1_bits_d;
    logic [POS_W-1:0] s1_pos_q,   s1_pos_d;
    logic             s1_zero_q,  s1_zero_d;

    logic             s2_valid_q, s2_valid_d;
    logic [POS_W-1:0] s2_pos_q,   s2_pos_d;
    logic             s2_zero_q,  s2_zero_d;
    logic [POS_W-1:0] s2_shift_q, s2_shift_d;
    logic [WIDTH-1:0] s2_norm_q,  s2_norm_d;

    logic s1_adv;
    logic s2_adv;

    // Stall control and next-state for both stages.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        s1_valid_d = s1_valid_q;
        s1_bits_d  = s1_bits_q;
        s1_pos_d   = s1_pos_q;
        s1_zero_d  = s1_zero_q;
        s2_valid_d = s2_valid_q;
        s2_pos_d   = s2_pos_q;
        s2_zero_d  = s2_zero_q;
        s2_shift_d = s2_shift_q;
        s2_norm_d  = s2_norm_q;

        s2_adv = !s2_valid_q || io.out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        if (s1_adv) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_bits_d = io.in_bits;
                s1_pos_d  = lead_pos(io.in_bits);
                s1_zero_d = (io.in_bits == '0);
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                // pos <= WIDTH, so WIDTH - pos fits in POS_W bits; a zero
                // word yields shift = WIDTH and norm = 0 naturally.
                s2_pos_d   = s1_pos_q;
                s2_zero_d  = s1_zero_q;
                s2_shift_d = WIDTH_P - s1_pos_q;
                s2_norm_d  = s1_bits_q << (WIDTH_P - s1_pos_q);
            end
        end
    end

    // Pipeline registers; reset clears valids and data so outputs read 0.
    // NOTE: data registers are reset too because the outputs must read 0 right after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_bits_q  <= '0;
            s1_pos_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_pos_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_shift_q <= '0;
            s2_norm_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_bits_q  <= s1_bits_d;
            s1_pos_q   <= s1_pos_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_pos_q   <= s2_pos_d;
            s2_zero_q  <= s2_zero_d;
            s2_shift_q <= s2_shift_d;
            s2_norm_q  <= s2_norm_d;
        end
    end

    assign io.in_ready  = s1_adv;
    assign io.out_valid = s2_valid_q;
    assign io.out_pos   = s2_pos_q;
    assign io.out_zero  = s2_zero_q;
    assign io.out_shift = s2_shift_q;
    assign io.out_norm  = s2_norm_q;

endmodule

// File: tb/tb_pipelined_lod_normalizer.sv
// Self-checking bench: a 23-bit and an 8-bit normaliser driven with directed
// and random beats, results compared in order against an arithmetic model.
module tb_pipelined_lod_normalizer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipelined_lod_normalizer_if #(.WIDTH(23)) io23 ();
    pipelined_lod_normalizer_if #(.WIDTH(8))  io8 ();

    pipelined_lod_normalizer #(.WIDTH(23)) u_dut23 (
        .clock (clk),
        .reset (rst),
        .io    (io23.slave)
    );

    pipelined_lod_normalizer #(.WIDTH(8)) u_dut8 (
        .clock (clk),
        .reset (rst),
        .io    (io8.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int step_cnt = 0;
    int last_emit = 0;
    int n_emit[2];
    bit hold_v[2];
    logic [63:0] hold_d[2];
    logic [63:0] q23[$];
    logic [63:0] q8[$];
    int emit_steps[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected result {pos, zero, shift, norm} for a w-bit word x.
    function automatic logic [63:0] model(input int w, input logic [31:0] x);
        longint p;
        longint s;
        logic [31:0] mask;
        logic [31:0] norm;
        p    = (x == 0) ? 0 : $clog2(longint'(x) + 1);
        s    = w - p;
        mask = (32'h1 << w) - 32'h1;
        norm = (x << s) & mask;
        return {15'd0, 8'(p), (x == 32'h0), 8'(s), norm};
    endfunction

    function automatic logic [63:0] obs23();
        return {15'd0, 8'(io23.out_pos), io23.out_zero, 8'(io23.out_shift), 32'(io23.out_norm)};
    endfunction

    function automatic logic [63:0] obs8();
        return {15'd0, 8'(io8.out_pos), io8.out_zero, 8'(io8.out_shift), 32'(io8.out_norm)};
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q23.size() : q8.size();
    endfunction

    // One cycle: drive at the falling edge, sample 1 ns later, update the
    // scoreboard for the transfers that happen at the next rising edge.
    task automatic step(input int sel, input bit iv, input logic [31:0] bits,
                        input bit ordy, output bit acc);
        logic [31:0] x;
        logic [63:0] o;
        logic [63:0] e;
        bit ov;
        bit ir;
        int occ;
        int w;
        w = (sel == 0) ? 23 : 8;
        x = (sel == 0) ? (bits & 32'h7FFFFF) : (bits & 32'hFF);
        io23.in_valid  = (sel == 0) && iv;
        io23.in_bits   = x[22:0];
        io23.out_ready = (sel == 0) ? ordy : 1'b1;
        io8.in_valid   = (sel == 1) && iv;
        io8.in_bits    = x[7:0];
        io8.out_ready  = (sel == 1) ? ordy : 1'b1;
        #1;
        if (sel == 0) begin
            ov = io23.out_valid; ir = io23.in_ready; o = obs23(); occ = q23.size();
        end else begin
            ov = io8.out_valid;  ir = io8.in_ready;  o = obs8();  occ = q8.size();
        end
        // Ready drops only with both slots full and the output stalled.
        check("in_ready", 64'(ir), (occ == 2 && !ordy) ? 64'd0 : 64'd1);
        if (hold_v[sel]) check("hold_stable", o, hold_d[sel]);
        hold_v[sel] = ov && !ordy;
        hold_d[sel] = o;
        if (ov) begin
            check("valid_has_beat", 64'(occ != 0), 64'd1);
            if (ordy && occ != 0) begin
                e = (sel == 0) ? q23.pop_front() : q8.pop_front();
                check((sel == 0) ? "result23" : "result8", o, e);
                n_emit[sel]++;
                last_emit = step_cnt;
                if (sel == 0) emit_steps.push_back(step_cnt);
            end
        end
        acc = iv && ir;
        if (acc) begin
            if (sel == 0) q23.push_back(model(w, x));
            else          q8.push_back(model(w, x));
        end
        @(negedge clk);
        step_cnt++;
    endtask

    task automatic drain(input int sel);
        int n;
        bit a;
        n = 0;
        while (qsize(sel) != 0 && n < 20) begin
            step(sel, 1'b0, $urandom, 1'b1, a);
            n++;
        end
        check("drain_empty", 64'(qsize(sel)), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid23", 64'(io23.out_valid), 64'd0);
        check("rst_data23",  obs23(), 64'd0);
        check("rst_valid8",  64'(io8.out_valid), 64'd0);
        check("rst_data8",   obs8(), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int a_step;
        int idx;
        int guard;
        int v;
        logic [31:0] t3_vals[4];
        logic [31:0] t4_vals[3];

        io23.in_valid = 1'b0; io23.in_bits = '0; io23.out_ready = 1'b1;
        io8.in_valid  = 1'b0; io8.in_bits  = '0; io8.out_ready  = 1'b1;
        n_emit[0] = 0; n_emit[1] = 0;
        hold_v[0] = 1'b0; hold_v[1] = 1'b0;

        // Power-on reset state.
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Single top-bit beat and its latency.
        a_step = step_cnt;
        step(0, 1'b1, 32'h400000, 1'b1, a);
        check("t1_accept", 64'(a), 64'd1);
        drain(0);
        check("t1_latency", 64'(last_emit - a_step), 64'd2);

        // Lowest bit, then an all-zero word.
        step(0, 1'b1, 32'h000001, 1'b1, a);
        step(0, 1'b1, 32'h000000, 1'b1, a);
        drain(0);

        // Back-to-back stream: one result per cycle.
        t3_vals = '{32'h1, 32'h3F, 32'h1000, 32'h7FFFFF};
        emit_steps.delete();
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, t3_vals[i], 1'b1, a);
            check("t3_accept", 64'(a), 64'd1);
        end
        drain(0);
        check("t3_emits", 64'(emit_steps.size()), 64'd4);
        for (int i = 1; i < emit_steps.size(); i++)
            check("t3_spacing", 64'(emit_steps[i] - emit_steps[i-1]), 64'd1);

        // Output stalled for five cycles while three beats are offered.
        t4_vals = '{32'h12345, 32'h2, 32'h0};
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(0, idx < 3, (idx < 3) ? t4_vals[idx] : 32'h0, 1'b0, a);
            if (a) idx++;
        end
        check("t4_buffered", 64'(idx), 64'd2);
        guard = 0;
        while (idx < 3 && guard < 10) begin
            step(0, 1'b1, t4_vals[idx], 1'b1, a);
            if (a) idx++;
            guard++;
        end
        check("t4_all_accepted", 64'(idx), 64'd3);
        drain(0);

        // Reset with two beats in flight.
        step(0, 1'b1, 32'h00F00F, 1'b0, a);
        step(0, 1'b1, 32'h000100, 1'b0, a);
        check("t5_in_flight", 64'(q23.size()), 64'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        q23.delete(); q8.delete();
        hold_v[0] = 1'b0; hold_v[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 1'b0, $urandom, 1'b1, a);

        // Random 23-bit traffic with varied magnitudes and random stalls.
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 3) != 0, $urandom >> $urandom_range(0, 31),
                 $urandom_range(0, 9) < 7, a);
        end
        drain(0);

        // 8-bit instance: every input value, random gaps and stalls.
        v = 0;
        guard = 0;
        while (v < 256 && guard < 5000) begin
            step(1, $urandom_range(0, 3) != 0, 32'(v), $urandom_range(0, 9) < 6, a);
            if (a) v++;
            guard++;
        end
        drain(1);
        check("t6_count", 64'(n_emit[1]), 64'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
